// File: rtl/fifo_pkg.sv
// Shared sizing and pointer helpers for the parameterised FIFO.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Increment with wrap at depth-1, so non-power-of-two depths work.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read-before-write: a read and write to the same entry returns the old word.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with arbitrary depth, occupancy flags and overflow/underflow pulses.
module fifo_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 10,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int CW       = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             w,
  input  logic             r,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_dout_valid, r_overflow, r_underflow;
  logic             r_have_rd;
  logic             w_rd_ok, w_wr_ok;
  logic [WIDTH-1:0] w_ram_q;

  assign empty        = (r_count == '0);
  assign full         = (r_count == CW'(DEPTH));
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign count        = r_count;

  assign w_rd_ok = r & ~empty;
  assign w_wr_ok = w & (~full | w_rd_ok);

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
    .clock   (clock),
    .i_we    (w_wr_ok & ~clr),
    .i_waddr (r_wptr),
    .i_wdata (DATAIN),
    .i_re    (w_rd_ok & ~clr),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_q)
  );

  // The RAM read register has no reset, so mask it until a post-reset read lands.
  assign DATAOUT = r_have_rd ? w_ram_q : '0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_have_rd    <= 1'b0;
    end else if (clr) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= PW'(ptr_inc(int'(r_wptr), DEPTH));
      if (w_rd_ok) begin
        r_rptr    <= PW'(ptr_inc(int'(r_rptr), DEPTH));
        r_have_rd <= 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_dout_valid <= w_rd_ok;
      r_overflow   <= w & ~w_wr_ok;
      r_underflow  <= r & empty;
    end
  end

  assign dout_valid = r_dout_valid;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule
